// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory subsystem.
// Holds the default RAM geometry and the encoding of the read-owner register.
package mem_pkg;

   localparam int unsigned MEM_AW = 12;   // default word-address width
   localparam int unsigned MEM_DW = 32;   // default data word width

   // Which requester owns the read currently in flight.
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/starve_counter.sv
// Saturating starvation counter for the DMA requester.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low reset, clears the count
//   inc      in   count one more denied cycle (saturates at LIMIT)
//   clr      in   clear the count to zero (wins over inc)
//   at_limit out  count has reached LIMIT
module starve_counter #(
   parameter int unsigned LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(LIMIT);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign at_limit = (count_q == LIM);

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !at_limit) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM with registered reads.
// The CPU has priority; the DMA port wins once it has been denied STARVE_LIMIT
// consecutive cycles. Read data is routed back to the requester that owned the
// read, one cycle after its grant.
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   cpu_req/wen/addr/wdata       CPU request (in)
//   cpu_gnt/rvalid/rdata         CPU grant and read return (out)
//   dma_req/wen/addr/wdata       DMA request (in)
//   dma_gnt/rvalid/rdata         DMA grant and read return (out)
//   ram_wen/addr/wdata           RAM command (out)
//   ram_rdata                    RAM read data, one cycle after address (in)
module dmem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned AW           = MEM_AW,
   parameter int unsigned DW           = MEM_DW,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clock,
   input  logic          reset,

   input  logic          cpu_req,
   input  logic          cpu_wen,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,

   input  logic          dma_req,
   input  logic          dma_wen,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,

   output logic          ram_wen,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   logic at_limit;
   logic dma_wins;
   logic pend_q;
   logic owner_q;
   logic rd_granted;

   // Grants are gated by reset so nothing is granted while reset is held low.
   assign dma_wins = dma_req & (~cpu_req | at_limit);
   assign dma_gnt  = reset & dma_wins;
   assign cpu_gnt  = reset & cpu_req & ~dma_wins;

   starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clock    (clock),
      .reset    (reset),
      .inc      (dma_req & ~dma_gnt),
      .clr      (~dma_req | dma_gnt),
      .at_limit (at_limit)
   );

   // With no grant the RAM sees the CPU address and zero write data.
   always_comb begin
      ram_addr  = cpu_addr;
      ram_wdata = '0;
      ram_wen   = 1'b0;
      if (dma_gnt) begin
         ram_addr  = dma_addr;
         ram_wdata = dma_wdata;
         ram_wen   = dma_wen;
      end else if (cpu_gnt) begin
         ram_wdata = cpu_wdata;
         ram_wen   = cpu_wen;
      end
   end

   assign rd_granted = (cpu_gnt & ~cpu_wen) | (dma_gnt & ~dma_wen);

   // Remember who owns the read whose data appears on ram_rdata next cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_q  <= 1'b0;
         owner_q <= OWN_CPU;
      end else begin
         pend_q  <= rd_granted;
         owner_q <= dma_gnt ? OWN_DMA : OWN_CPU;
      end
   end

   always_comb begin
      cpu_rvalid = pend_q & (owner_q == OWN_CPU);
      dma_rvalid = pend_q & (owner_q == OWN_DMA);
      cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
      dma_rdata  = dma_rvalid ? ram_rdata : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int LIMIT = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          cpu_req = 1'b0, cpu_wen = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          dma_req = 1'b0, dma_wen = 1'b0;
   logic [AW-1:0] dma_addr = '0;
   logic [DW-1:0] dma_wdata = '0;
   logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_wen;
   logic [DW-1:0] cpu_rdata, dma_rdata, ram_wdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   dmem_arbiter #(
      .AW (AW), .DW (DW), .STARVE_LIMIT (LIMIT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_wen    (cpu_wen),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dma_req    (dma_req),
      .dma_wen    (dma_wen),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .ram_wen    (ram_wen),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   // Initial RAM image; word 0x010 holds the known constant used by the read test.
   function automatic logic [DW-1:0] init_word(int a);
      if (a == 'h010) return 32'hDEADBEEF;
      return (32'(a) * 32'h9E3779B1) ^ 32'h0000A5A5;
   endfunction

   // Registered-read RAM attached to the DUT; reloads its image during reset.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
         ram_rdata <= '0;
      end else begin
         if (ram_wen) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   // Reference model: streak of denied DMA cycles, expected RAM contents and
   // the read expected to return next cycle.
   int            m_streak;
   bit            m_pend, m_own_dma;
   logic [DW-1:0] m_data;
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   task automatic model_reset();
      m_streak = 0;
      m_pend   = 0;
      m_own_dma = 0;
      m_data   = '0;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
   endtask

   function automatic void model_grants(output bit cg, output bit dg);
      dg = dma_req && (!cpu_req || m_streak >= LIMIT);
      cg = cpu_req && !dg;
   endfunction

   // Commit the current cycle to the model and move to the next falling edge.
   task automatic advance();
      bit cg, dg, wen;
      logic [AW-1:0] a;
      model_grants(cg, dg);
      if (cg || dg) begin
         wen = dg ? dma_wen : cpu_wen;
         a   = dg ? dma_addr : cpu_addr;
         m_pend    = !wen;
         m_own_dma = dg;
         m_data    = ref_mem[a];
         if (wen) ref_mem[a] = dg ? dma_wdata : cpu_wdata;
      end else begin
         m_pend = 0;
      end
      if (dma_req && !dg) m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
      else m_streak = 0;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle();
      cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_wen = 0; dma_addr = '0; dma_wdata = '0;
   endtask

   task automatic test_reset();
      reset = 0;
      model_reset();
      cpu_req = 1; cpu_wen = 1; cpu_addr = 12'h123; cpu_wdata = 32'hFFFF_0000;
      dma_req = 1; dma_wen = 1; dma_addr = 12'h456;
      repeat (2) @(negedge clock);
      #1;
      n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_gnt got %b want 0", cpu_gnt); end
      n_checks++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_dma_gnt got %b want 0", dma_gnt); end
      n_checks++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid got %b want 00", {cpu_rvalid, dma_rvalid}); end
      n_checks++; if (ram_wen !== 1'b0) begin n_fail++; $display("FAIL rst_ram_wen got %b want 0", ram_wen); end
      n_checks++; if (ram_addr !== 12'h123 || ram_wdata !== '0) begin n_fail++; $display("FAIL rst_ram_idle got %h/%h want 123/0", ram_addr, ram_wdata); end
      idle();
      reset = 1;
      @(negedge clock);
   endtask

   task automatic test_cpu_read();
      cpu_req = 1; cpu_wen = 0; cpu_addr = 12'h010;
      #1;
      n_checks++; if ({cpu_gnt, dma_gnt} !== 2'b10) begin n_fail++; $display("FAIL cpurd_gnt got %b want 10", {cpu_gnt, dma_gnt}); end
      advance();
      idle();
      #1;
      n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpurd_data got %b/%h want 1/deadbeef", cpu_rvalid, cpu_rdata); end
      n_checks++; if (dma_rvalid !== 1'b0 || dma_rdata !== '0) begin n_fail++; $display("FAIL cpurd_dma_quiet got %b/%h want 0/0", dma_rvalid, dma_rdata); end
      advance();
   endtask

   task automatic test_starve();
      bit cg, dg;
      for (int c = 0; c < 7; c++) begin
         cpu_req = 1; cpu_wen = 0; cpu_addr = AW'($urandom);
         dma_req = 1; dma_wen = 0; dma_addr = AW'($urandom);
         #1;
         model_grants(cg, dg);
         n_checks++; if ({cpu_gnt, dma_gnt} !== {cg, dg}) begin n_fail++; $display("FAIL starve_model cyc %0d got %b want %b", c, {cpu_gnt, dma_gnt}, {cg, dg}); end
         n_checks++; if (dma_gnt !== (c == 4)) begin n_fail++; $display("FAIL starve_pattern cyc %0d dma_gnt got %b want %b", c, dma_gnt, (c == 4)); end
         advance();
      end
      idle();
      advance();
   endtask

   task automatic test_alternate();
      bit cg, dg;
      for (int c = 0; c < 4; c++) begin
         idle();
         if (c == 0) begin cpu_req = 1; cpu_addr = 12'h001; end
         if (c == 1) begin dma_req = 1; dma_addr = 12'h002; end
         if (c == 2) begin cpu_req = 1; cpu_addr = 12'h003; end
         #1;
         model_grants(cg, dg);
         n_checks++; if ({cpu_gnt, dma_gnt} !== {cg, dg}) begin n_fail++; $display("FAIL alt_gnt cyc %0d got %b want %b", c, {cpu_gnt, dma_gnt}, {cg, dg}); end
         n_checks++; if ({cpu_rvalid, dma_rvalid} !== {c == 1 || c == 3, c == 2}) begin n_fail++; $display("FAIL alt_rvalid cyc %0d got %b", c, {cpu_rvalid, dma_rvalid}); end
         n_checks++; if (cpu_rdata !== ((m_pend && !m_own_dma) ? m_data : '0)) begin n_fail++; $display("FAIL alt_cpu_rdata cyc %0d got %h want %h", c, cpu_rdata, m_data); end
         n_checks++; if (dma_rdata !== ((m_pend && m_own_dma) ? m_data : '0)) begin n_fail++; $display("FAIL alt_dma_rdata cyc %0d got %h want %h", c, dma_rdata, m_data); end
         advance();
      end
   endtask

   task automatic test_write_read();
      idle();
      dma_req = 1; dma_wen = 1; dma_addr = 12'h0FF; dma_wdata = 32'h12345678;
      #1;
      n_checks++; if (dma_gnt !== 1'b1 || ram_wen !== 1'b1) begin n_fail++; $display("FAIL wr_gnt_wen got %b/%b want 1/1", dma_gnt, ram_wen); end
      n_checks++; if (ram_addr !== 12'h0FF || ram_wdata !== 32'h12345678) begin n_fail++; $display("FAIL wr_ram got %h/%h want 0ff/12345678", ram_addr, ram_wdata); end
      advance();
      idle();
      cpu_req = 1; cpu_addr = 12'h0FF;
      #1;
      n_checks++; if (cpu_gnt !== 1'b1 || ram_wen !== 1'b0) begin n_fail++; $display("FAIL rd_gnt_wen got %b/%b want 1/0", cpu_gnt, ram_wen); end
      n_checks++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin n_fail++; $display("FAIL wr_no_rvalid got %b want 00", {cpu_rvalid, dma_rvalid}); end
      advance();
      idle();
      #1;
      n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin n_fail++; $display("FAIL wr_rd_data got %b/%h want 1/12345678", cpu_rvalid, cpu_rdata); end
      n_checks++; if (ram_wen !== 1'b0) begin n_fail++; $display("FAIL wr_rd_idle_wen got %b want 0", ram_wen); end
      advance();
   endtask

   task automatic test_reset_inflight();
      idle();
      cpu_req = 1; cpu_addr = 12'h020;
      #1;
      n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rif_gnt got %b want 1", cpu_gnt); end
      advance();
      reset = 0;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++; if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_wen} !== 5'b0) begin n_fail++; $display("FAIL rif_held cyc %0d got %b want 00000", c, {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_wen}); end
         @(posedge clock);
         @(negedge clock);
      end
      reset = 1;
      cpu_addr = 12'h030;
      #1;
      n_checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== '0) begin n_fail++; $display("FAIL rif_no_rvalid got %b/%h want 0/0", cpu_rvalid, cpu_rdata); end
      n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rif_first_arb got %b want 1", cpu_gnt); end
      advance();
      idle();
      #1;
      n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== init_word('h030)) begin n_fail++; $display("FAIL rif_after_data got %b/%h want 1/%h", cpu_rvalid, cpu_rdata, init_word('h030)); end
      advance();
   endtask

   task automatic test_starve_drop();
      bit cg, dg;
      for (int c = 0; c < 9; c++) begin
         cpu_req = 1; cpu_wen = 0; cpu_addr = AW'($urandom);
         dma_req = (c != 3); dma_wen = 0; dma_addr = AW'($urandom);
         #1;
         model_grants(cg, dg);
         n_checks++; if ({cpu_gnt, dma_gnt} !== {cg, dg}) begin n_fail++; $display("FAIL drop_model cyc %0d got %b want %b", c, {cpu_gnt, dma_gnt}, {cg, dg}); end
         n_checks++; if (dma_gnt !== (c == 8)) begin n_fail++; $display("FAIL drop_pattern cyc %0d dma_gnt got %b want %b", c, dma_gnt, (c == 8)); end
         advance();
      end
      idle();
      advance();
   endtask

   task automatic test_random();
      bit cg, dg;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      bit e_wen;
      for (int c = 0; c < 400; c++) begin
         cpu_req = 1'($urandom); cpu_wen = 1'($urandom); cpu_addr = AW'($urandom_range(0, 15));
         cpu_wdata = $urandom;
         dma_req = ($urandom_range(0, 3) != 0); dma_wen = 1'($urandom);
         dma_addr = AW'($urandom_range(0, 15)); dma_wdata = $urandom;
         #1;
         model_grants(cg, dg);
         e_addr  = dg ? dma_addr : cpu_addr;
         e_wdata = dg ? dma_wdata : (cg ? cpu_wdata : '0);
         e_wen   = (dg && dma_wen) || (cg && cpu_wen);
         n_checks++; if ({cpu_gnt, dma_gnt} !== {cg, dg}) begin n_fail++; $display("FAIL rand_gnt cyc %0d got %b want %b", c, {cpu_gnt, dma_gnt}, {cg, dg}); end
         n_checks++; if ({ram_wen, ram_addr, ram_wdata} !== {e_wen, e_addr, e_wdata}) begin n_fail++; $display("FAIL rand_ram cyc %0d got %b/%h/%h want %b/%h/%h", c, ram_wen, ram_addr, ram_wdata, e_wen, e_addr, e_wdata); end
         n_checks++; if ({cpu_rvalid, dma_rvalid} !== {m_pend && !m_own_dma, m_pend && m_own_dma}) begin n_fail++; $display("FAIL rand_rvalid cyc %0d got %b", c, {cpu_rvalid, dma_rvalid}); end
         n_checks++; if (cpu_rdata !== ((m_pend && !m_own_dma) ? m_data : '0)) begin n_fail++; $display("FAIL rand_cpu_rdata cyc %0d got %h want %h", c, cpu_rdata, m_data); end
         n_checks++; if (dma_rdata !== ((m_pend && m_own_dma) ? m_data : '0)) begin n_fail++; $display("FAIL rand_dma_rdata cyc %0d got %h want %h", c, dma_rdata, m_data); end
         advance();
      end
      idle();
      advance();
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_starve();
      test_alternate();
      test_write_read();
      test_reset_inflight();
      test_starve_drop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 12, word-address width presented to the data RAM.
REQ-002 Parameter DW, default 32, data word width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive denied DMA-request cycles before DMA is forced to win.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU requests a RAM access this cycle.
REQ-007 cpu_wen  in  1  CPU access is a write (1) or a read (0).
REQ-008 cpu_addr  in  AW  CPU word address.
REQ-009 cpu_wdata  in  DW  CPU write data.
REQ-010 cpu_gnt  out  1  CPU access accepted this cycle.
REQ-011 cpu_rvalid  out  1  cpu_rdata is valid this cycle.
REQ-012 cpu_rdata  out  DW  CPU read data.
REQ-013 dma_req, dma_wen, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata SHALL be identical in direction, width and meaning to the CPU set, serving the loader/debug DMA port.
REQ-014 ram_wen  out  1  RAM write enable.
REQ-015 ram_addr  out  AW  RAM address.
REQ-016 ram_wdata  out  DW  RAM write data.
REQ-017 ram_rdata  in  DW  RAM registered read data, valid one cycle after the address.

Function
REQ-018 At most one of cpu_gnt and dma_gnt SHALL be 1 in any cycle; a grant SHALL be asserted only to a requester whose req is 1.
REQ-019 Grants SHALL be combinational from the current req inputs and registered state, with no request-to-grant latency.
REQ-020 Default priority: CPU wins when both request, unless starve_cnt equals STARVE_LIMIT, in which case DMA wins.
REQ-021 starve_cnt SHALL increment, saturating at STARVE_LIMIT, in each cycle where dma_req=1 and dma_gnt=0; it SHALL clear to 0 on any cycle with dma_gnt=1 or dma_req=0.
REQ-022 ram_addr, ram_wdata and ram_wen SHALL be muxed from the granted requester; ram_wen SHALL be 0 when no grant is issued or the granted access is a read.
REQ-023 With no grant, ram_addr SHALL hold the CPU address and ram_wdata 0.
REQ-024 A granted read SHALL produce that requester's rvalid=1 exactly one cycle after the grant, with rdata equal to ram_rdata in that cycle.
REQ-025 A one-bit owner register plus a pending flag SHALL record the granted read; the non-owner's rvalid SHALL stay 0.
REQ-026 Granted writes SHALL NOT produce rvalid.
REQ-027 Back-to-back reads, including reads alternating between requesters, SHALL sustain one access per cycle, each rvalid routed to the correct owner.
REQ-028 rdata outputs SHALL be ram_rdata when the port's rvalid=1 and 0 otherwise.
REQ-029 A read granted in the same cycle as a write to the same address by the other requester cannot occur (REQ-018); write-then-read ordering follows grant order.

Reset
REQ-030 While reset=0: cpu_gnt=dma_gnt=0, cpu_rvalid=dma_rvalid=0, ram_wen=0, starve_cnt=0, pending flag=0.
REQ-031 Reset asserted with a read in flight SHALL discard that read; no rvalid SHALL follow reset deassertion.
REQ-032 The first cycle after deassertion SHALL arbitrate normally.

Structure
REQ-033 AW, DW defaults and the owner encoding (OWN_CPU=0, OWN_DMA=1) SHALL live in the shared mem_pkg package.
REQ-034 The starvation counter SHALL be a sub-module named starve_counter (increment, clear, saturate, at_limit output).

Verification
REQ-035 CPU read addr 0x010 alone (RAM word 0x010 = 0xDEADBEEF) -> cpu_gnt=1 in cycle 0; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF in cycle 1; dma_rvalid stays 0.
REQ-036 Both request continuously with STARVE_LIMIT=4 -> CPU granted in cycles 0-3, DMA in cycle 4, starve_cnt back to 0 in cycle 5, then CPU again.
REQ-037 Alternating reads CPU@0x001, DMA@0x002, CPU@0x003 on consecutive cycles -> rvalid alternates CPU/DMA/CPU with the correct data, one per cycle.
REQ-038 DMA write 0x12345678 to 0x0FF, then CPU read of 0x0FF -> ram_wen=1 only in the write cycle; cpu_rdata=0x12345678; no rvalid for the write.
REQ-039 reset driven low in the cycle after a CPU read grant -> cpu_rvalid=0 throughout and after reset; all outputs at reset values.
REQ-040 dma_req drops at starve_cnt=3, then reasserts -> counter clears to 0; the CPU keeps priority for 4 more cycles.
